// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the register-slave bus: bus widths,
// response codes and the command-master FSM state encoding.
package axi_lite_pkg;

  localparam int unsigned AXI4L_ADDR_W = 16;
  localparam int unsigned DATA_W       = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } axil_state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single-word read/write commands into one
// AXI4-Lite transaction at a time, with a per-transaction timeout.
// Ports:
//   SysClk_ClkIn / SysRstN_RstIn : clock, async active-low reset
//   Cmd*        : command handshake (valid/ready), write flag, address, data
//   Rsp*        : one-cycle completion pulse with data, response, timeout flag
//   AxiWrite*   : AW / W / B channels (WSTRB 4'hF, AWPROT 0)
//   AxiRead*    : AR / R channels (ARPROT 0)
// All outputs are registered; no combinational input-to-output path.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] Timeout_Gen = 32'd1024
) (
  input  logic                    SysClk_ClkIn,
  input  logic                    SysRstN_RstIn,
  input  logic                    CmdValid_ValIn,
  output logic                    CmdReady_RdyOut,
  input  logic                    CmdWrite_EnaIn,
  input  logic [AXI4L_ADDR_W-1:0] CmdAddress_AdrIn,
  input  logic [DATA_W-1:0]       CmdData_DatIn,
  output logic                    RspValid_ValOut,
  output logic [DATA_W-1:0]       RspData_DatOut,
  output logic [1:0]              RspResponse_DatOut,
  output logic                    RspTimeout_EvtOut,
  output logic                    AxiWriteAddrValid_ValOut,
  input  logic                    AxiWriteAddrReady_RdyIn,
  output logic [AXI4L_ADDR_W-1:0] AxiWriteAddrAddress_AdrOut,
  output logic [2:0]              AxiWriteAddrProt_DatOut,
  output logic                    AxiWriteDataValid_ValOut,
  input  logic                    AxiWriteDataReady_RdyIn,
  output logic [DATA_W-1:0]       AxiWriteDataData_DatOut,
  output logic [3:0]              AxiWriteDataStrobe_DatOut,
  input  logic                    AxiWriteRespValid_ValIn,
  output logic                    AxiWriteRespReady_RdyOut,
  input  logic [1:0]              AxiWriteRespResponse_DatIn,
  output logic                    AxiReadAddrValid_ValOut,
  input  logic                    AxiReadAddrReady_RdyIn,
  output logic [AXI4L_ADDR_W-1:0] AxiReadAddrAddress_AdrOut,
  output logic [2:0]              AxiReadAddrProt_DatOut,
  input  logic                    AxiReadDataValid_ValIn,
  output logic                    AxiReadDataReady_RdyOut,
  input  logic [1:0]              AxiReadDataResponse_DatIn,
  input  logic [DATA_W-1:0]       AxiReadDataData_DatIn
);

  // Word alignment: low two address bits are forced to zero.
  localparam logic [AXI4L_ADDR_W-1:0] ADDR_ALIGN_MASK = {{(AXI4L_ADDR_W-2){1'b1}}, 2'b00};

  axil_state_e             state_q;
  logic                    cmd_ready_q;
  logic [AXI4L_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    rsp_valid_q, rsp_timeout_q;
  logic [DATA_W-1:0]       rsp_data_q;
  logic [1:0]              rsp_resp_q;
  logic [31:0]             tmo_cnt_q;

  logic aw_done, w_done, tmo_hit;

  // A write channel counts as done once its valid is low (already handshaked)
  // or is handshaking this cycle.
  always_comb begin
    aw_done = !awvalid_q || AxiWriteAddrReady_RdyIn;
    w_done  = !wvalid_q  || AxiWriteDataReady_RdyIn;
    tmo_hit = (Timeout_Gen != '0) && (state_q != ST_IDLE) &&
              (tmo_cnt_q == Timeout_Gen - 32'd1);
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      if (state_q != ST_IDLE) tmo_cnt_q <= tmo_cnt_q + 32'd1;

      // Timeout overrides every state: drop all AXI handshake outputs at once.
      if (tmo_hit) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        rsp_valid_q   <= 1'b1;
        rsp_timeout_q <= 1'b1;
        rsp_resp_q    <= AXI_RESP_SLVERR;
        rsp_data_q    <= '0;
        cmd_ready_q   <= 1'b1;
        state_q       <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!cmd_ready_q) begin
              cmd_ready_q <= 1'b1;
            end else if (CmdValid_ValIn) begin
              cmd_ready_q <= 1'b0;
              addr_q      <= CmdAddress_AdrIn & ADDR_ALIGN_MASK;
              wdata_q     <= CmdData_DatIn;
              tmo_cnt_q   <= '0;
              if (CmdWrite_EnaIn) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= ST_WR_REQ;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= ST_RD_REQ;
              end
            end
          end
          ST_WR_REQ: begin
            if (awvalid_q && AxiWriteAddrReady_RdyIn) awvalid_q <= 1'b0;
            if (wvalid_q  && AxiWriteDataReady_RdyIn) wvalid_q  <= 1'b0;
            if (aw_done && w_done) begin
              bready_q <= 1'b1;
              state_q  <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
            if (AxiWriteRespValid_ValIn) begin
              bready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_resp_q  <= AxiWriteRespResponse_DatIn;
              rsp_data_q  <= '0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          ST_RD_REQ: begin
            if (AxiReadAddrReady_RdyIn) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= ST_RD_RESP;
            end
          end
          ST_RD_RESP: begin
            if (AxiReadDataValid_ValIn) begin
              rready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_resp_q  <= AxiReadDataResponse_DatIn;
              rsp_data_q  <= AxiReadDataData_DatIn;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign CmdReady_RdyOut            = cmd_ready_q;
  assign RspValid_ValOut            = rsp_valid_q;
  assign RspData_DatOut             = rsp_data_q;
  assign RspResponse_DatOut         = rsp_resp_q;
  assign RspTimeout_EvtOut          = rsp_timeout_q;
  assign AxiWriteAddrValid_ValOut   = awvalid_q;
  assign AxiWriteAddrAddress_AdrOut = addr_q;
  assign AxiWriteAddrProt_DatOut    = 3'b000;
  assign AxiWriteDataValid_ValOut   = wvalid_q;
  assign AxiWriteDataData_DatOut    = wdata_q;
  assign AxiWriteDataStrobe_DatOut  = 4'hF;
  assign AxiWriteRespReady_RdyOut   = bready_q;
  assign AxiReadAddrValid_ValOut    = arvalid_q;
  assign AxiReadAddrAddress_AdrOut  = addr_q;
  assign AxiReadAddrProt_DatOut     = 3'b000;
  assign AxiReadDataReady_RdyOut    = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a hand-driven AXI4-Lite slave.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CmdValid, CmdReady, CmdWrite;
  logic [15:0] CmdAddress;
  logic [31:0] CmdData;
  logic        RspValid, RspTimeout;
  logic [31:0] RspData;
  logic [1:0]  RspResponse;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [15:0] AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  int total = 0;
  int bad   = 0;
  int nrsp;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.Timeout_Gen(32'd16)) dut (
    .SysClk_ClkIn               (clk),
    .SysRstN_RstIn              (rst_n),
    .CmdValid_ValIn             (CmdValid),
    .CmdReady_RdyOut            (CmdReady),
    .CmdWrite_EnaIn             (CmdWrite),
    .CmdAddress_AdrIn           (CmdAddress),
    .CmdData_DatIn              (CmdData),
    .RspValid_ValOut            (RspValid),
    .RspData_DatOut             (RspData),
    .RspResponse_DatOut         (RspResponse),
    .RspTimeout_EvtOut          (RspTimeout),
    .AxiWriteAddrValid_ValOut   (AWVALID),
    .AxiWriteAddrReady_RdyIn    (AWREADY),
    .AxiWriteAddrAddress_AdrOut (AWADDR),
    .AxiWriteAddrProt_DatOut    (AWPROT),
    .AxiWriteDataValid_ValOut   (WVALID),
    .AxiWriteDataReady_RdyIn    (WREADY),
    .AxiWriteDataData_DatOut    (WDATA),
    .AxiWriteDataStrobe_DatOut  (WSTRB),
    .AxiWriteRespValid_ValIn    (BVALID),
    .AxiWriteRespReady_RdyOut   (BREADY),
    .AxiWriteRespResponse_DatIn (BRESP),
    .AxiReadAddrValid_ValOut    (ARVALID),
    .AxiReadAddrReady_RdyIn     (ARREADY),
    .AxiReadAddrAddress_AdrOut  (ARADDR),
    .AxiReadAddrProt_DatOut     (ARPROT),
    .AxiReadDataValid_ValIn     (RVALID),
    .AxiReadDataReady_RdyOut    (RREADY),
    .AxiReadDataResponse_DatIn  (RRESP),
    .AxiReadDataData_DatIn      (RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Write: AW ready at WR_REQ cycle aw_dly, W ready at cycle w_dly,
  // BVALID at WR_RESP cycle b_dly.
  task automatic write_txn(input string tag, input logic [15:0] addr, input logic [15:0] exp_addr,
                           input logic [31:0] data, input int unsigned aw_dly,
                           input int unsigned w_dly, input int unsigned b_dly, input logic [1:0] bresp);
    int unsigned last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    chk({tag, " cmdrdy"}, 32'(CmdReady), 32'd1);
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddress = addr; CmdData = data;
    step();
    CmdValid = 1'b0; CmdAddress = 16'hFFFF; CmdData = 32'h0;
    chk({tag, " cmdrdy_drop"}, 32'(CmdReady), 32'd0);
    for (int unsigned k = 0; k <= last; k++) begin
      chk({tag, " awvalid"}, 32'(AWVALID), 32'(k <= aw_dly));
      chk({tag, " wvalid"},  32'(WVALID),  32'(k <= w_dly));
      chk({tag, " bready_req"}, 32'(BREADY), 32'd0);
      if (k <= aw_dly) chk({tag, " awaddr"}, 32'(AWADDR), 32'(exp_addr));
      if (k <= w_dly) begin
        chk({tag, " wdata"}, WDATA, data);
        chk({tag, " wstrb"}, 32'(WSTRB), 32'hF);
      end
      AWREADY = (k >= aw_dly);
      WREADY  = (k >= w_dly);
      step();
    end
    AWREADY = 1'b0; WREADY = 1'b0;
    for (int unsigned j = 0; j <= b_dly; j++) begin
      chk({tag, " bready"},  32'(BREADY), 32'd1);
      chk({tag, " aw_off"},  32'(AWVALID), 32'd0);
      chk({tag, " w_off"},   32'(WVALID), 32'd0);
      chk({tag, " rsp_early"}, 32'(RspValid), 32'd0);
      BVALID = (j == b_dly); BRESP = bresp;
      step();
    end
    BVALID = 1'b0; BRESP = 2'b00;
    chk({tag, " rspvalid"}, 32'(RspValid), 32'd1);
    chk({tag, " rspresp"},  32'(RspResponse), 32'(bresp));
    chk({tag, " rspdata"},  RspData, 32'd0);
    chk({tag, " rsptmo"},   32'(RspTimeout), 32'd0);
    chk({tag, " cmdrdy_back"}, 32'(CmdReady), 32'd1);
    chk({tag, " bready_off"}, 32'(BREADY), 32'd0);
    step();
    chk({tag, " rsp_pulse"}, 32'(RspValid), 32'd0);
  endtask

  // Read: ARREADY at RD_REQ cycle ar_dly, RVALID at RD_RESP cycle r_dly.
  task automatic read_txn(input string tag, input logic [15:0] addr, input logic [15:0] exp_addr,
                          input int unsigned ar_dly, input int unsigned r_dly,
                          input logic [31:0] rdata, input logic [1:0] rresp);
    chk({tag, " cmdrdy"}, 32'(CmdReady), 32'd1);
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddress = addr; CmdData = 32'h5555_AAAA;
    step();
    CmdValid = 1'b0; CmdAddress = 16'hFFFF;
    chk({tag, " cmdrdy_drop"}, 32'(CmdReady), 32'd0);
    for (int unsigned k = 0; k <= ar_dly; k++) begin
      chk({tag, " arvalid"}, 32'(ARVALID), 32'd1);
      chk({tag, " araddr"},  32'(ARADDR), 32'(exp_addr));
      chk({tag, " arprot"},  32'(ARPROT), 32'd0);
      chk({tag, " rready_req"}, 32'(RREADY), 32'd0);
      ARREADY = (k == ar_dly);
      step();
    end
    ARREADY = 1'b0;
    for (int unsigned j = 0; j <= r_dly; j++) begin
      chk({tag, " rready"},  32'(RREADY), 32'd1);
      chk({tag, " ar_off"},  32'(ARVALID), 32'd0);
      chk({tag, " rsp_early"}, 32'(RspValid), 32'd0);
      RVALID = (j == r_dly);
      RDATA  = (j == r_dly) ? rdata : ~rdata;
      RRESP  = rresp;
      step();
    end
    RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    chk({tag, " rspvalid"}, 32'(RspValid), 32'd1);
    chk({tag, " rspdata"},  RspData, rdata);
    chk({tag, " rspresp"},  32'(RspResponse), 32'(rresp));
    chk({tag, " rsptmo"},   32'(RspTimeout), 32'd0);
    chk({tag, " cmdrdy_back"}, 32'(CmdReady), 32'd1);
    step();
    chk({tag, " rsp_pulse"}, 32'(RspValid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    CmdValid = 1'b0; CmdWrite = 1'b0; CmdAddress = '0; CmdData = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
    step(); step();

    // Reset state
    chk("rst cmdrdy",  32'(CmdReady), 32'd0);
    chk("rst rspvalid", 32'(RspValid), 32'd0);
    chk("rst awvalid", 32'(AWVALID), 32'd0);
    chk("rst wvalid",  32'(WVALID), 32'd0);
    chk("rst arvalid", 32'(ARVALID), 32'd0);
    chk("rst bready",  32'(BREADY), 32'd0);
    chk("rst rready",  32'(RREADY), 32'd0);
    chk("rst awprot",  32'(AWPROT), 32'd0);
    rst_n = 1'b1;
    chk("rel cmdrdy_low", 32'(CmdReady), 32'd0);
    step();
    chk("rel cmdrdy_high", 32'(CmdReady), 32'd1);

    // 1: basic write, low address bits ignored
    write_txn("t1", 16'h0012, 16'h0010, 32'hDEAD_BEEF, 0, 0, 1, 2'b00);

    // 2: independent AW/W handshakes
    write_txn("t2a", 16'h0104, 16'h0104, 32'h1111_2222, 0, 3, 0, 2'b10);
    write_txn("t2b", 16'h0208, 16'h0208, 32'h3333_4444, 3, 0, 2, 2'b11);
    write_txn("t2c", 16'h030F, 16'h030C, 32'h5555_6666, 2, 2, 0, 2'b00);

    // 3: read with 5 wait cycles on R
    read_txn("t3", 16'h0000, 16'h0000, 0, 5, 32'h0001_0000, 2'b00);

    // 4: timeout with a silent slave (Timeout_Gen=16)
    chk("t4 cmdrdy", 32'(CmdReady), 32'd1);
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddress = 16'h0020;
    step();
    CmdValid = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      chk("t4 arvalid_hold", 32'(ARVALID), 32'd1);
      chk("t4 no_rsp", 32'(RspValid), 32'd0);
      step();
    end
    chk("t4 rspvalid", 32'(RspValid), 32'd1);
    chk("t4 rsptmo",   32'(RspTimeout), 32'd1);
    chk("t4 rspresp",  32'(RspResponse), 32'd2);
    chk("t4 rspdata",  RspData, 32'd0);
    chk("t4 ar_drop",  32'(ARVALID), 32'd0);
    chk("t4 rready",   32'(RREADY), 32'd0);
    chk("t4 cmdrdy_back", 32'(CmdReady), 32'd1);
    RVALID = 1'b1; RDATA = 32'hBAD0_BAD0;
    step();
    RVALID = 1'b0;
    chk("t4 late_r_ignored", 32'(RspValid), 32'd0);
    chk("t4 tmo_pulse", 32'(RspTimeout), 32'd0);
    chk("t4 late_rready", 32'(RREADY), 32'd0);

    // 5: reset while in WR_RESP
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddress = 16'h0040; CmdData = 32'h0BAD_F00D;
    AWREADY = 1'b1; WREADY = 1'b1;
    step();
    CmdValid = 1'b0;
    step();
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("t5 in_wr_resp", 32'(BREADY), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async bready", 32'(BREADY), 32'd0);
    chk("t5 async cmdrdy", 32'(CmdReady), 32'd0);
    chk("t5 async awvalid", 32'(AWVALID), 32'd0);
    chk("t5 async wvalid", 32'(WVALID), 32'd0);
    chk("t5 async rspvalid", 32'(RspValid), 32'd0);
    chk("t5 async awaddr", 32'(AWADDR), 32'd0);
    chk("t5 async wdata", WDATA, 32'd0);
    BVALID = 1'b1;
    step(); step();
    chk("t5 no_rsp_in_rst", 32'(RspValid), 32'd0);
    rst_n = 1'b1; BVALID = 1'b0;
    chk("t5 rel cmdrdy_low", 32'(CmdReady), 32'd0);
    step();
    chk("t5 rel cmdrdy_high", 32'(CmdReady), 32'd1);
    chk("t5 no_rsp_after", 32'(RspValid), 32'd0);
    read_txn("t5r", 16'h0008, 16'h0008, 1, 0, 32'hA5A5_0F0F, 2'b00);

    // 6: back-to-back read then write with CmdValid held high, zero-wait slave
    nrsp = 0;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b11;
    ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hCAFE_0001; RRESP = 2'b00;
    chk("t6 cmdrdy", 32'(CmdReady), 32'd1);
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddress = 16'h0004; CmdData = 32'h0;
    step(); nrsp += int'(RspValid);
    chk("t6 rd_accept", 32'(CmdReady), 32'd0);
    chk("t6 arvalid", 32'(ARVALID), 32'd1);
    CmdWrite = 1'b1; CmdAddress = 16'h0008; CmdData = 32'h1234_5678;
    step(); nrsp += int'(RspValid);
    chk("t6 rready", 32'(RREADY), 32'd1);
    step(); nrsp += int'(RspValid);
    chk("t6 rd_rsp", 32'(RspValid), 32'd1);
    chk("t6 rd_data", RspData, 32'hCAFE_0001);
    chk("t6 rd_cmdrdy", 32'(CmdReady), 32'd1);
    step(); nrsp += int'(RspValid);
    CmdValid = 1'b0;
    chk("t6 wr_accept", 32'(CmdReady), 32'd0);
    chk("t6 awvalid", 32'(AWVALID), 32'd1);
    chk("t6 awaddr", 32'(AWADDR), 32'h0008);
    chk("t6 wdata", WDATA, 32'h1234_5678);
    step(); nrsp += int'(RspValid);
    chk("t6 bready", 32'(BREADY), 32'd1);
    step(); nrsp += int'(RspValid);
    chk("t6 wr_rsp", 32'(RspValid), 32'd1);
    chk("t6 wr_resp", 32'(RspResponse), 32'd3);
    chk("t6 wr_data", RspData, 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(); nrsp += int'(RspValid);
    end
    chk("t6 rsp_count", 32'(nrsp), 32'd2);
    chk("t6 idle_cmdrdy", 32'(CmdReady), 32'd1);
    chk("t6 idle_arvalid", 32'(ARVALID), 32'd0);
    chk("t6 idle_awvalid", 32'(AWVALID), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
